// File: rtl/instr_encoder_if.sv
// Handshake bundle between the program loader and the RV32I instruction encoder.
// The slave modport is the encoder side and the master modport is the loader/sink side.
`timescale 1ns/1ps

interface instr_encoder_if #(
    parameter int ADDR_W   = 10,
    parameter int ERRCNT_W = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_op;
    logic [4:0]          in_rd;
    logic [4:0]          in_rs1;
    logic [4:0]          in_rs2;
    logic [31:0]         in_imm;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_instr;
    logic [ADDR_W-1:0]   out_addr;
    logic                out_err;
    logic [ERRCNT_W-1:0] err_cnt;

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
    );

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: symbolic fields in, 32-bit words tagged with a word address out,
// through a single registered output stage with valid/ready on both sides.
`timescale 1ns/1ps

module instr_encoder #(
    parameter int ADDR_W   = 10,
    parameter int ERRCNT_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    instr_encoder_if.slave  bus
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_SLTU = 4'd5,
        OP_ADDI = 4'd6,
        OP_LW   = 4'd7,
        OP_SW   = 4'd8,
        OP_BEQ  = 4'd9,
        OP_JAL  = 4'd10,
        OP_JALR = 4'd11
    } op_e;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_BAD
    } fmt_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // True when v, read as signed, fits in a two's-complement field of the given width.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] top;
        top = $signed(v) >>> (bits - 1);
        return (top == 32'sd0) || (top == -32'sd1);
    endfunction

    op_e         op;
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] enc;
    logic        imm_ok;
    logic        word_err;
    logic [31:0] word;

    logic                valid_q;
    logic [31:0]         instr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                err_q;
    logic [ERRCNT_W-1:0] err_cnt_q;
    logic [ADDR_W-1:0]   addr_cnt;

    logic accept;
    logic xfer;

    assign op  = op_e'(bus.in_op);
    assign imm = bus.in_imm;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        fmt    = FMT_BAD;
        opcode = '0;
        funct3 = '0;
        funct7 = '0;
        case (op)
            OP_ADD:  begin fmt = FMT_R; opcode = OPC_OP; end
            OP_SUB:  begin fmt = FMT_R; opcode = OPC_OP; funct7 = 7'b0100000; end
            OP_AND:  begin fmt = FMT_R; opcode = OPC_OP; funct3 = 3'b111; end
            OP_OR:   begin fmt = FMT_R; opcode = OPC_OP; funct3 = 3'b110; end
            OP_SLT:  begin fmt = FMT_R; opcode = OPC_OP; funct3 = 3'b010; end
            OP_SLTU: begin fmt = FMT_R; opcode = OPC_OP; funct3 = 3'b011; end
            OP_ADDI: begin fmt = FMT_I; opcode = OPC_OP_IMM; end
            OP_LW:   begin fmt = FMT_I; opcode = OPC_LOAD;   funct3 = 3'b010; end
            OP_JALR: begin fmt = FMT_I; opcode = OPC_JALR; end
            OP_SW:   begin fmt = FMT_S; opcode = OPC_STORE;  funct3 = 3'b010; end
            OP_BEQ:  begin fmt = FMT_B; opcode = OPC_BRANCH; end
            OP_JAL:  begin fmt = FMT_J; opcode = OPC_JAL; end
            default: fmt = FMT_BAD;
        endcase
    end

    // Field packing per format; branch and jump offsets are byte offsets, so bit 0 must be clear.
    always_comb begin
        enc    = '0;
        imm_ok = 1'b0;
        case (fmt)
            FMT_R: begin
                enc    = {funct7, bus.in_rs2, bus.in_rs1, funct3, bus.in_rd, opcode};
                imm_ok = 1'b1;
            end
            FMT_I: begin
                enc    = {imm[11:0], bus.in_rs1, funct3, bus.in_rd, opcode};
                imm_ok = fits_signed(imm, 12);
            end
            FMT_S: begin
                enc    = {imm[11:5], bus.in_rs2, bus.in_rs1, funct3, imm[4:0], opcode};
                imm_ok = fits_signed(imm, 12);
            end
            FMT_B: begin
                enc    = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, funct3,
                          imm[4:1], imm[11], opcode};
                imm_ok = fits_signed(imm, 13) && !imm[0];
            end
            FMT_J: begin
                enc    = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, opcode};
                imm_ok = fits_signed(imm, 21) && !imm[0];
            end
            default: begin
                enc    = '0;
                imm_ok = 1'b0;
            end
        endcase
    end

    assign word_err = (fmt == FMT_BAD) || !imm_ok;
    assign word     = word_err ? '0 : enc;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            addr_cnt  <= '0;
        end else begin
            if (accept) begin
                valid_q <= 1'b1;
                instr_q <= word;
                err_q   <= word_err;
                addr_q  <= clear ? '0 : addr_cnt;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end

            // clear wins over the increment; a word accepted alongside it takes address 0.
            if (clear) begin
                addr_cnt <= ADDR_W'(accept);
            end else if (accept) begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
            end

            if (xfer && err_q && !(&err_cnt_q)) begin
                err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_addr  = addr_q;
    assign bus.out_err   = err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a wide-address and a 2-bit-address instance share
// the same stimulus; monitors pop expected words whenever a transfer happens.
`timescale 1ns/1ps

module tb_instr_encoder;

    localparam int ADDR_W   = 10;
    localparam int ERRCNT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) bus ();
    instr_encoder_if #(.ADDR_W(2),      .ERRCNT_W(ERRCNT_W)) wbus ();

    instr_encoder #(.ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    instr_encoder #(.ADDR_W(2), .ERRCNT_W(ERRCNT_W)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (wbus)
    );

    assign wbus.in_valid  = bus.in_valid;
    assign wbus.in_op     = bus.in_op;
    assign wbus.in_rd     = bus.in_rd;
    assign wbus.in_rs1    = bus.in_rs1;
    assign wbus.in_rs2    = bus.in_rs2;
    assign wbus.in_imm    = bus.in_imm;
    assign wbus.out_ready = bus.out_ready;

    typedef struct {
        logic [31:0]       instr;
        logic              err;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t sb_q[$];
    exp_t wsb_q[$];

    int n_vec     = 0;
    int n_miss    = 0;
    int exp_addr  = 0;
    int err_seen  = 0;
    int last_wait = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Main monitor: contents, address, error flag, and error count seen with each transferred word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb_q.delete();
            err_seen = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                flag($sformatf("unexpected_word instr=%h", bus.out_instr));
            end else begin
                e = sb_q.pop_front();
                check("instr",   bus.out_instr, e.instr);
                check("err",     32'(bus.out_err), 32'(e.err));
                check("addr",    32'(bus.out_addr), 32'(e.addr));
                check("err_cnt", 32'(bus.err_cnt), (err_seen > 255) ? 255 : err_seen);
                if (e.err) err_seen++;
            end
        end
    end

    // Narrow-address monitor: same words, address taken modulo 4.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            wsb_q.delete();
        end else if (wbus.out_valid && wbus.out_ready) begin
            if (wsb_q.size() == 0) begin
                flag($sformatf("wrap_unexpected_word instr=%h", wbus.out_instr));
            end else begin
                e = wsb_q.pop_front();
                check("wrap_instr", wbus.out_instr, e.instr);
                check("wrap_addr",  32'(wbus.out_addr), 32'(e.addr[1:0]));
            end
        end
    end

    task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm,
                        input logic [31:0] exp_instr, input int exp_err, input int clr);
        exp_t e;
        bus.in_op    = op[3:0];
        bus.in_rd    = rd[4:0];
        bus.in_rs1   = rs1[4:0];
        bus.in_rs2   = rs2[4:0];
        bus.in_imm   = imm;
        bus.in_valid = 1'b1;
        clear        = (clr != 0);
        last_wait    = 0;
        @(negedge clk);
        while (!bus.in_ready && last_wait < 50) begin
            last_wait++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            flag("accept_timeout");
        end else begin
            e.instr  = exp_instr;
            e.err    = (exp_err != 0);
            e.addr   = (clr != 0) ? '0 : exp_addr[ADDR_W-1:0];
            exp_addr = (int'(e.addr) + 1) % (1 << ADDR_W);
            sb_q.push_back(e);
            wsb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || wsb_q.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb_q.size() != 0 || wsb_q.size() != 0) flag("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int a_addr;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b0;

        #22;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_instr", bus.out_instr, 0);
        check("rst_out_addr",  32'(bus.out_addr), 0);
        check("rst_out_err",   32'(bus.out_err), 0);
        check("rst_err_cnt",   32'(bus.err_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        check("idle_in_ready", 32'(bus.in_ready), 1);

        // First word and its one-cycle latency.
        send(0, 3, 1, 2, 0, 32'h002081B3, 0, 0);
        check("latency_valid", 32'(bus.out_valid), 1);

        // Back-to-back stream; no stall expected on any of them.
        send(1, 5, 6, 7, 0,  32'h407302B3, 0, 0); check("stream_ready_sub",  last_wait, 0);
        send(6, 1, 0, 0, -1, 32'hFFF00093, 0, 0); check("stream_ready_addi", last_wait, 0);
        send(8, 0, 1, 2, 8,  32'h0020A423, 0, 0); check("stream_ready_sw",   last_wait, 0);
        send(9, 0, 1, 2, -4, 32'hFE208EE3, 0, 0); check("stream_ready_beq",  last_wait, 0);
        send(10, 1, 0, 0, 8, 32'h008000EF, 0, 0); check("stream_ready_jal",  last_wait, 0);

        // Remaining R-type ops and immediate range boundaries that must still encode.
        send(2, 4, 5, 6, 0,        32'h0062F233, 0, 0);
        send(3, 7, 8, 9, 0,        32'h009463B3, 0, 0);
        send(4, 1, 2, 3, 0,        32'h003120B3, 0, 0);
        send(5, 1, 2, 3, 0,        32'h003130B3, 0, 0);
        send(7, 5, 2, 0, -2048,    32'h80012283, 0, 0);
        send(11, 0, 1, 0, 2047,    32'h7FF08067, 0, 0);
        send(6, 2, 3, 0, 2047,     32'h7FF18113, 0, 0);
        send(8, 0, 4, 3, -1,       32'hFE322FA3, 0, 0);
        send(9, 0, 0, 0, 4094,     32'h7E000FE3, 0, 0);
        send(9, 0, 0, 0, -4096,    32'h80000063, 0, 0);
        send(10, 0, 0, 0, -1048576, 32'h8000006F, 0, 0);
        send(10, 2, 0, 0, 1048574, 32'h7FFFF16F, 0, 0);
        drain();

        // Backpressure: hold a word for three cycles, clearing the counter mid-stall.
        bus.out_ready = 1'b0;
        a_addr = exp_addr;
        send(0, 3, 1, 2, 0, 32'h002081B3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) clear = 1'b1;
            @(negedge clk);
            check("stall_in_ready",  32'(bus.in_ready), 0);
            check("stall_out_valid", 32'(bus.out_valid), 1);
            check("stall_out_instr", bus.out_instr, 32'h002081B3);
            check("stall_out_addr",  32'(bus.out_addr), a_addr);
            @(posedge clk);
            #1;
            clear = 1'b0;
        end
        exp_addr = 0;
        bus.out_ready = 1'b1;
        send(1, 5, 6, 7, 0, 32'h407302B3, 0, 0);

        // clear together with an accept: that word gets 0, the next gets 1.
        send(2, 4, 5, 6, 0, 32'h0062F233, 0, 0);
        send(3, 7, 8, 9, 0, 32'h009463B3, 0, 1);
        send(4, 1, 2, 3, 0, 32'h003120B3, 0, 0);
        drain();

        // Error words still occupy addresses.
        send(6, 1, 0, 0, 2048, 32'h0, 1, 0);
        send(9, 0, 1, 2, 3,    32'h0, 1, 0);
        send(13, 1, 2, 3, 0,   32'h0, 1, 0);
        drain();
        check("err_cnt_three", 32'(bus.err_cnt), 3);
        send(7, 1, 2, 0, -2049,   32'h0, 1, 0);
        send(9, 0, 1, 2, 4096,    32'h0, 1, 0);
        send(10, 1, 0, 0, 1048576, 32'h0, 1, 0);
        send(10, 1, 0, 0, 5,      32'h0, 1, 0);
        send(8, 0, 1, 2, 2048,    32'h0, 1, 0);
        send(0, 3, 1, 2, 0,       32'h002081B3, 0, 0);
        drain();
        check("err_cnt_eight", 32'(bus.err_cnt), 8);

        // Asynchronous reset while a word is held under backpressure.
        bus.out_ready = 1'b0;
        send(1, 5, 6, 7, 0, 32'h407302B3, 0, 0);
        check("pre_reset_valid", 32'(bus.out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",   32'(bus.out_valid), 0);
        check("async_rst_instr",   bus.out_instr, 0);
        check("async_rst_err_cnt", 32'(bus.err_cnt), 0);
        check("async_rst_addr",    32'(bus.out_addr), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_addr = 0;
        bus.out_ready = 1'b1;

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) send(15, 0, 0, 0, 0, 32'h0, 1, 0);
        drain();
        check("err_cnt_saturated", 32'(bus.err_cnt), 255);

        send(0, 3, 1, 2, 0, 32'h002081B3, 0, 0);
        drain();
        check("sb_empty",      sb_q.size(), 0);
        check("wrap_sb_empty", wsb_q.size(), 0);
        check("final_idle",    32'(bus.out_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
